instr_fetch_ctrl: RTL and testbench

- Sequences the instruction-memory transmitter through its syn/ack handshake and fetches one complete program of DEPTH instructions per start command.
- Buffers the fetched words in a small FIFO and presents them to the decode stage with a valid/ready interface, each tagged with its byte PC.
- Uses credit-based flow control so a stalled decode stage never causes an instruction to be lost.

---
 rtl/instr_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives the instruction-memory transmitter's
// syn/ack handshake for one DEPTH-word program per start pulse. Fetched words
// are buffered in a small first-word-fall-through FIFO and handed to decode
// over valid/ready. Credit gating on syn guarantees the FIFO never overflows.
module instr_fetch_ctrl #(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 36,
  parameter int FDEPTH = 4,
  parameter int AWIDTH = 8
) (
  input  logic              t_clk,
  input  logic              t_rst,
  input  logic              c_i_start,
  output logic              c_o_busy,
  output logic              c_o_done,
  output logic              f_o_syn,
  input  logic [IWIDTH-1:0] f_i_instr,
  input  logic              f_i_ack,
  output logic [IWIDTH-1:0] d_o_instr,
  output logic [AWIDTH-1:0] d_o_pc,
  output logic              d_o_valid,
  input  logic              d_i_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(FDEPTH);
  localparam int NW = $clog2(FDEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              syn_q, syn_d;
  logic [CW-1:0]     issue_q, issue_d;
  logic [CW-1:0]     deliv_q, deliv_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [IWIDTH-1:0] mem_q [FDEPTH];
  logic              push, pop;
  logic [31:0]       issued_next;
  logic [31:0]       credit_need;

  // syn requests issued or in flight after this edge, and FIFO slots they could
  // occupy. Pops are ignored on purpose: conservative but never overflows.
  assign issued_next = 32'(issue_q) + 32'(syn_q);
  assign credit_need = 32'(cnt_q) + 32'(f_i_ack) + 32'(syn_q) + 32'd1;

  // Next-state, counters, FIFO pointers and handshake request
  always_comb begin
    state_d = state_q;
    syn_d   = 1'b0;
    issue_d = issue_q;
    deliv_d = deliv_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    // Words arriving while idle are stray and dropped.
    push    = f_i_ack && (state_q == S_FETCH || state_q == S_DRAIN);
    pop     = (cnt_q != '0) && d_i_ready;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop) begin
      rptr_d  = rptr_q + PW'(1);
      deliv_d = deliv_q + CW'(1);
    end
    cnt_d = cnt_q + NW'(push) - NW'(pop);
    case (state_q)
      S_IDLE: begin
        if (c_i_start) begin
          state_d = S_FETCH;
          syn_d   = 1'b1;   // empty FIFO always has credit for the first word
          issue_d = '0;
          deliv_d = '0;
          wptr_d  = '0;
          rptr_d  = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (syn_q) issue_d = issue_q + CW'(1);
        syn_d = (issued_next < 32'(DEPTH)) && (credit_need <= 32'(FDEPTH));
        if (issued_next >= 32'(DEPTH)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == '0 && !f_i_ack) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and pointer registers; reset also realigns with the transmitter
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      state_q <= S_IDLE;
      syn_q   <= 1'b0;
      issue_q <= '0;
      deliv_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      syn_q   <= syn_d;
      issue_q <= issue_d;
      deliv_q <= deliv_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage; contents are only visible while valid, so no reset needed
  always_ff @(posedge t_clk) begin
    if (push) mem_q[wptr_q] <= f_i_instr;
  end

  // Delivery is in order, so the head PC follows directly from deliv_q.
  assign d_o_valid = (cnt_q != '0);
  assign d_o_instr = d_o_valid ? mem_q[rptr_q] : '0;
  assign d_o_pc    = d_o_valid ? AWIDTH'({deliv_q, 2'b00}) : '0;
  assign f_o_syn   = syn_q;
  assign c_o_busy  = (state_q != S_IDLE);
  assign c_o_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural transmitter model.
module tb_instr_fetch_ctrl;

  localparam int IW = 32;
  localparam int DP = 36;
  localparam int FD = 4;
  localparam int AW = 8;

  logic          t_clk = 1'b0;
  logic          t_rst;
  logic          c_i_start;
  logic          c_o_busy, c_o_done, f_o_syn;
  logic [IW-1:0] f_i_instr;
  logic          f_i_ack;
  logic [IW-1:0] d_o_instr;
  logic [AW-1:0] d_o_pc;
  logic          d_o_valid;
  logic          d_i_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  // transmitter model
  logic [IW-1:0] tmem [DP];
  int            tptr;
  logic          tx_ack;
  logic [IW-1:0] tx_instr;
  logic          force_ack;

  // observation state
  logic [IW-1:0] q_instr[$];
  logic [AW-1:0] q_pc[$];
  int syn_cnt, done_cnt, occ, max_occ;

  always #5 t_clk = ~t_clk;

  instr_fetch_ctrl #(.IWIDTH(IW), .DEPTH(DP), .FDEPTH(FD), .AWIDTH(AW)) dut (
    .t_clk(t_clk), .t_rst(t_rst), .c_i_start(c_i_start),
    .c_o_busy(c_o_busy), .c_o_done(c_o_done), .f_o_syn(f_o_syn),
    .f_i_instr(f_i_instr), .f_i_ack(f_i_ack),
    .d_o_instr(d_o_instr), .d_o_pc(d_o_pc), .d_o_valid(d_o_valid),
    .d_i_ready(d_i_ready)
  );

  assign f_i_instr = tx_instr;
  assign f_i_ack   = tx_ack | force_ack;

  // transmitter: one word per sampled syn, pointer wraps at DP
  always @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      tptr <= 0; tx_ack <= 1'b0; tx_instr <= '0;
    end else begin
      tx_ack <= f_o_syn;
      if (f_o_syn) begin
        tx_instr <= tmem[tptr];
        tptr     <= (tptr == DP - 1) ? 0 : tptr + 1;
      end
    end
  end

  // monitor: record pops, count syn/done cycles, track FIFO occupancy
  always @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      occ <= 0;
    end else begin
      automatic int n = occ + ((f_i_ack && c_o_busy) ? 1 : 0)
                            - ((d_o_valid && d_i_ready) ? 1 : 0);
      occ <= n;
      if (n > max_occ) max_occ <= n;
      if (f_o_syn) syn_cnt <= syn_cnt + 1;
      if (c_o_done) done_cnt <= done_cnt + 1;
      if (d_o_valid && d_i_ready) begin
        q_instr.push_back(d_o_instr);
        q_pc.push_back(d_o_pc);
      end
    end
  end

  task automatic pulse_start();
    @(negedge t_clk); c_i_start = 1'b1;
    @(negedge t_clk); c_i_start = 1'b0;
  endtask

  task automatic test_reset();
    t_rst = 1'b0;
    repeat (3) @(negedge t_clk);
    total_cnt++;
    if ({c_o_busy, c_o_done, f_o_syn, d_o_valid} !== 4'b0 || d_o_instr !== '0 || d_o_pc !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b syn=%b valid=%b instr=%h pc=%h want all 0",
               c_o_busy, c_o_done, f_o_syn, d_o_valid, d_o_instr, d_o_pc);
    else pass_cnt++;
    t_rst = 1'b1;
    repeat (50) @(negedge t_clk);
    total_cnt++;
    if (syn_cnt !== 0) $display("FAIL idle_no_syn got %0d syn cycles want 0", syn_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({c_o_busy, c_o_done, d_o_valid} !== 3'b0)
      $display("FAIL idle_outputs got busy=%b done=%b valid=%b want 0", c_o_busy, c_o_done, d_o_valid);
    else pass_cnt++;
  endtask

  task automatic test_full_ready();
    int k, bad, s0, d0;
    q_instr.delete(); q_pc.delete();
    s0 = syn_cnt; d0 = done_cnt; max_occ = 0;
    d_i_ready = 1'b1;
    pulse_start();
    total_cnt++;
    if ({c_o_busy, f_o_syn, d_o_valid} !== 3'b110)
      $display("FAIL start_e0 got busy=%b syn=%b valid=%b want 1 1 0", c_o_busy, f_o_syn, d_o_valid);
    else pass_cnt++;
    @(negedge t_clk);
    total_cnt++;
    if (d_o_valid !== 1'b0) $display("FAIL latency_e1 got valid=%b want 0", d_o_valid);
    else pass_cnt++;
    @(negedge t_clk);
    total_cnt++;
    if (d_o_valid !== 1'b1 || d_o_instr !== tmem[0] || d_o_pc !== 8'd0)
      $display("FAIL latency_e2 got valid=%b instr=%h pc=%0d want 1 %h 0", d_o_valid, d_o_instr, d_o_pc, tmem[0]);
    else pass_cnt++;
    k = 3;
    while (!c_o_done && k < 300) begin @(negedge t_clk); k++; end
    total_cnt++;
    if (k !== 40) $display("FAIL full_done_cycle got %0d want 40", k);
    else pass_cnt++;
    repeat (3) @(negedge t_clk);
    bad = 0;
    foreach (q_instr[i]) if (q_instr[i] !== tmem[i % DP] || q_pc[i] !== AW'(4 * i)) bad++;
    total_cnt++;
    if (q_instr.size() !== DP || bad !== 0)
      $display("FAIL full_words got %0d words %0d wrong want %0d words 0 wrong", q_instr.size(), bad, DP);
    else pass_cnt++;
    total_cnt++;
    if (syn_cnt - s0 !== DP || done_cnt - d0 !== 1)
      $display("FAIL full_counts got syn=%0d done=%0d want %0d 1", syn_cnt - s0, done_cnt - d0, DP);
    else pass_cnt++;
    total_cnt++;
    if (c_o_busy !== 1'b0 || d_o_valid !== 1'b0)
      $display("FAIL full_idle got busy=%b valid=%b want 0 0", c_o_busy, d_o_valid);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int k, bad, s0;
    q_instr.delete(); q_pc.delete();
    s0 = syn_cnt;
    d_i_ready = 1'b0;
    pulse_start();
    repeat (19) @(negedge t_clk);
    total_cnt++;
    if (syn_cnt - s0 !== FD) $display("FAIL stall_syn got %0d syn cycles want %0d", syn_cnt - s0, FD);
    else pass_cnt++;
    total_cnt++;
    if (d_o_valid !== 1'b1 || d_o_instr !== tmem[0] || d_o_pc !== 8'd0 || q_instr.size() !== 0)
      $display("FAIL stall_head got valid=%b instr=%h pc=%0d pops=%0d want 1 %h 0 0",
               d_o_valid, d_o_instr, d_o_pc, q_instr.size(), tmem[0]);
    else pass_cnt++;
    d_i_ready = 1'b1;
    k = 0;
    while (!c_o_done && k < 300) begin @(negedge t_clk); k++; end
    total_cnt++;
    if (!c_o_done) $display("FAIL stall_timeout got no done want done within 300 cycles");
    else pass_cnt++;
    repeat (2) @(negedge t_clk);
    bad = 0;
    foreach (q_instr[i]) if (q_instr[i] !== tmem[i % DP] || q_pc[i] !== AW'(4 * i)) bad++;
    total_cnt++;
    if (q_instr.size() !== DP || bad !== 0 || syn_cnt - s0 !== DP)
      $display("FAIL stall_words got %0d words %0d wrong %0d syn want %0d 0 %0d",
               q_instr.size(), bad, syn_cnt - s0, DP, DP);
    else pass_cnt++;
  endtask

  task automatic test_random_ready();
    int k, bad;
    q_instr.delete(); q_pc.delete();
    max_occ = 0;
    pulse_start();
    for (k = 0; k < 600; k++) begin
      @(negedge t_clk);
      if (c_o_done) break;
      d_i_ready = 1'($urandom_range(0, 1));
    end
    d_i_ready = 1'b1;
    total_cnt++;
    if (!c_o_done) $display("FAIL random_timeout got no done want done within 600 cycles");
    else pass_cnt++;
    repeat (2) @(negedge t_clk);
    bad = 0;
    foreach (q_instr[i]) if (q_instr[i] !== tmem[i % DP] || q_pc[i] !== AW'(4 * i)) bad++;
    total_cnt++;
    if (q_instr.size() !== DP || bad !== 0)
      $display("FAIL random_words got %0d words %0d wrong want %0d 0", q_instr.size(), bad, DP);
    else pass_cnt++;
    total_cnt++;
    if (max_occ > FD) $display("FAIL random_occupancy got %0d want <= %0d", max_occ, FD);
    else pass_cnt++;
    // second run must restart at mem[0]
    q_instr.delete(); q_pc.delete();
    pulse_start();
    repeat (2) @(negedge t_clk);
    total_cnt++;
    if (d_o_valid !== 1'b1 || d_o_instr !== tmem[0] || d_o_pc !== 8'd0)
      $display("FAIL rerun_head got valid=%b instr=%h pc=%0d want 1 %h 0", d_o_valid, d_o_instr, d_o_pc, tmem[0]);
    else pass_cnt++;
    k = 0;
    while (!c_o_done && k < 300) begin @(negedge t_clk); k++; end
    repeat (2) @(negedge t_clk);
    bad = 0;
    foreach (q_instr[i]) if (q_instr[i] !== tmem[i % DP] || q_pc[i] !== AW'(4 * i)) bad++;
    total_cnt++;
    if (q_instr.size() !== DP || bad !== 0)
      $display("FAIL rerun_words got %0d words %0d wrong want %0d 0", q_instr.size(), bad, DP);
    else pass_cnt++;
  endtask

  task automatic test_spurious();
    int k, bad, s0, d0;
    q_instr.delete(); q_pc.delete();
    s0 = syn_cnt; d0 = done_cnt;
    d_i_ready = 1'b1;
    @(negedge t_clk); force_ack = 1'b1;
    repeat (2) @(negedge t_clk); force_ack = 1'b0;
    @(negedge t_clk);
    total_cnt++;
    if (d_o_valid !== 1'b0 || c_o_busy !== 1'b0 || q_instr.size() !== 0)
      $display("FAIL idle_ack_dropped got valid=%b busy=%b pops=%0d want 0 0 0", d_o_valid, c_o_busy, q_instr.size());
    else pass_cnt++;
    pulse_start();
    repeat (8) @(negedge t_clk);
    c_i_start = 1'b1;
    @(negedge t_clk); c_i_start = 1'b0;
    k = 0;
    while (!c_o_done && k < 300) begin @(negedge t_clk); k++; end
    repeat (2) @(negedge t_clk);
    bad = 0;
    foreach (q_instr[i]) if (q_instr[i] !== tmem[i % DP] || q_pc[i] !== AW'(4 * i)) bad++;
    total_cnt++;
    if (q_instr.size() !== DP || bad !== 0)
      $display("FAIL midstart_words got %0d words %0d wrong want %0d 0", q_instr.size(), bad, DP);
    else pass_cnt++;
    total_cnt++;
    if (syn_cnt - s0 !== DP || done_cnt - d0 !== 1)
      $display("FAIL midstart_counts got syn=%0d done=%0d want %0d 1", syn_cnt - s0, done_cnt - d0, DP);
    else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    int k, bad;
    q_instr.delete(); q_pc.delete();
    d_i_ready = 1'b1;
    pulse_start();
    k = 0;
    while (q_instr.size() < 10 && k < 200) begin @(negedge t_clk); k++; end
    total_cnt++;
    if (q_instr.size() < 10) $display("FAIL midrun_timeout got %0d pops want 10", q_instr.size());
    else pass_cnt++;
    t_rst = 1'b0;
    #1;
    total_cnt++;
    if ({c_o_busy, c_o_done, f_o_syn, d_o_valid} !== 4'b0 || d_o_instr !== '0 || d_o_pc !== '0)
      $display("FAIL midrun_reset got busy=%b done=%b syn=%b valid=%b instr=%h pc=%h want all 0",
               c_o_busy, c_o_done, f_o_syn, d_o_valid, d_o_instr, d_o_pc);
    else pass_cnt++;
    repeat (2) @(negedge t_clk);
    t_rst = 1'b1;
    @(negedge t_clk);
    q_instr.delete(); q_pc.delete();
    pulse_start();
    k = 0;
    while (!c_o_done && k < 300) begin @(negedge t_clk); k++; end
    repeat (2) @(negedge t_clk);
    bad = 0;
    foreach (q_instr[i]) if (q_instr[i] !== tmem[i % DP] || q_pc[i] !== AW'(4 * i)) bad++;
    total_cnt++;
    if (q_instr.size() !== DP || bad !== 0)
      $display("FAIL post_reset_words got %0d words %0d wrong want %0d 0", q_instr.size(), bad, DP);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got simulation still running want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DP; i++) tmem[i] = {8'(i + 1), 24'($urandom)};
    syn_cnt = 0; done_cnt = 0; max_occ = 0;
    t_rst = 1'b0; c_i_start = 1'b0; d_i_ready = 1'b0; force_ack = 1'b0;
    test_reset();
    test_full_ready();
    test_stall();
    test_random_ready();
    test_spurious();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
